// File: rtl/wb_queue.sv
// Writeback queue: merges pipeline (in0) and multi-cycle unit (in1) register writes
// into one register-file write port, with decode-stage forwarding from queued entries.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in0_valid,
  input  logic [ADDR_W-1:0]        in0_addr,
  input  logic [DATA_W-1:0]        in0_data,
  input  logic                     in1_valid,
  input  logic [ADDR_W-1:0]        in1_addr,
  input  logic [DATA_W-1:0]        in1_data,
  output logic                     in1_ready,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_push0;
  logic              w_acc1;
  logic              w_push1;
  logic              w_pop;
  logic [PTR_W-1:0]  w_slot1;
  logic [DATA_W:0]   w_look1;
  logic [DATA_W:0]   w_look2;

  // Writes to r0 are architecturally meaningless, so they never take a slot.
  assign w_push0 = in0_valid && (in0_addr != '0);
  assign w_acc1  = in1_valid && in1_ready;
  assign w_push1 = w_acc1 && (in1_addr != '0);
  assign w_pop   = (r_count != '0);
  assign w_slot1 = r_tail + PTR_W'(w_push0);

  assign in1_ready = (r_count != CNT_W'(DEPTH));
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;

  assign we    = w_pop;
  assign waddr = w_pop ? r_addr[r_head] : '0;
  assign wdata = w_pop ? r_data[r_head] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_push0) + PTR_W'(w_push1);
      r_count <= r_count + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_pop);
    end
  end

  // Storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_addr[r_tail] <= in0_addr;
      r_data[r_tail] <= in0_data;
    end
    if (w_push1) begin
      r_addr[w_slot1] <= in1_addr;
      r_data[w_slot1] <= in1_data;
    end
  end

  // Scan oldest to youngest so the youngest match wins; returns {hit, data}.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (a != '0) && (r_addr[idx] == a))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    w_look1 = lookup(fwd_addr1);
    w_look2 = lookup(fwd_addr2);
  end

  assign fwd_hit1  = w_look1[DATA_W];
  assign fwd_data1 = w_look1[DATA_W-1:0];
  assign fwd_hit2  = w_look2[DATA_W];
  assign fwd_data2 = w_look2[DATA_W-1:0];

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a list-based model predicts occupancy, forwarding
// and the exact sequence of register writes; a monitor checks each write as it appears.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_valid, in1_valid, in1_ready;
  logic [AW-1:0] in0_addr, in1_addr, waddr, fwd_addr1, fwd_addr2;
  logic [DW-1:0] in0_data, in1_data, wdata, fwd_data1, fwd_data2;
  logic          we, fwd_hit1, fwd_hit2, full, empty;
  logic [$clog2(DEPTH):0] count;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
    .in1_ready(in1_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];   // model contents: entries still waiting to be written
  ent_t exq[$];  // expected register writes, in order
  int   total = 0;
  int   bad   = 0;

  logic          p0v, p1v;
  logic [AW-1:0] p0a, p1a;
  logic [DW-1:0] p0d, p1d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every write the DUT presents must be the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && we === 1'b1) begin
        if (exq.size() == 0) begin
          chk("unexpected_write", {27'd0, waddr}, 32'hFFFF_FFFF);
        end else begin
          chk("wr_addr", {27'd0, waddr}, {27'd0, exq[0].a});
          chk("wr_data", wdata, exq[0].d);
          exq.delete(0);
        end
      end
    end
  end

  // One cycle: retire the previous edge into the model, check state, drive new inputs.
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] f1, input logic [AW-1:0] f2);
    logic          h1, h2;
    logic [DW-1:0] e1, e2;
    @(posedge clk);
    #1;
    if (mq.size() > 0) mq.delete(0);
    if (p0v && p0a != 0) mq.push_back('{a: p0a, d: p0d});
    if (p1v && p1a != 0) mq.push_back('{a: p1a, d: p1d});

    chk("count", {29'd0, count}, mq.size());
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("in1_ready", {31'd0, in1_ready}, {31'd0, mq.size() != DEPTH});
    chk("we", {31'd0, we}, {31'd0, mq.size() != 0});

    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
    fwd_addr1 = f1; fwd_addr2 = f2;
    p0v = v0; p0a = a0; p0d = d0;
    p1v = v1 && (mq.size() != DEPTH); p1a = a1; p1d = d1;
    if (p0v && p0a != 0) exq.push_back('{a: p0a, d: p0d});
    if (p1v && p1a != 0) exq.push_back('{a: p1a, d: p1d});

    h1 = 0; e1 = 0; h2 = 0; e2 = 0;
    foreach (mq[i]) begin
      if (f1 != 0 && mq[i].a == f1) begin h1 = 1; e1 = mq[i].d; end
      if (f2 != 0 && mq[i].a == f2) begin h2 = 1; e2 = mq[i].d; end
    end
    #1;
    chk("fwd_hit1", {31'd0, fwd_hit1}, {31'd0, h1});
    chk("fwd_data1", fwd_data1, e1);
    chk("fwd_hit2", {31'd0, fwd_hit2}, {31'd0, h2});
    chk("fwd_data2", fwd_data2, e2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; called right after a step.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
    in0_valid = 0; in1_valid = 0;
    mq.delete(); exq.delete();
    p0v = 0; p1v = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    in0_valid = 0; in0_addr = 0; in0_data = 0;
    in1_valid = 0; in1_addr = 0; in1_data = 0;
    fwd_addr1 = 0; fwd_addr2 = 0;
    p0v = 0; p0a = 0; p0d = 0; p1v = 0; p1a = 0; p1d = 0;
    #3;
    chk("init_we", {31'd0, we}, 32'd0);
    chk("init_count", {29'd0, count}, 32'd0);
    chk("init_in1_ready", {31'd0, in1_ready}, 32'd1);
    #9 rst = 1'b1;

    // Single write: latency one cycle, then empty again.
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("single_we_lat0", {31'd0, we}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    chk("single_we", {31'd0, we}, 32'd1);
    chk("single_waddr", {27'd0, waddr}, 32'd3);
    chk("single_wdata", wdata, 32'hDEADBEEF);
    chk("single_count1", {29'd0, count}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("single_we_after", {31'd0, we}, 32'd0);
    chk("single_count0", {29'd0, count}, 32'd0);

    // Dual push: in0 older than in1.
    step(1, 5, 32'h11, 1, 6, 32'h22, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dual_first", {27'd0, waddr}, 32'd5);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dual_second", {27'd0, waddr}, 32'd6);
    chk("dual_second_d", wdata, 32'h22);
    idle(2);

    // Fill: both sources every cycle; in1 stalls at full, in0 keeps flowing.
    for (int i = 0; i < 8; i++)
      step(1, AW'(8 + i), 32'h100 + i, 1, AW'(16 + i), 32'h200 + i, 0, 0);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_in1_ready", {31'd0, in1_ready}, 32'd0);
    idle(DEPTH + 2);

    // Address zero is dropped on both inputs.
    step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    chk("zero_in1_ready", {31'd0, in1_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_count", {29'd0, count}, 32'd0);
    chk("zero_we", {31'd0, we}, 32'd0);

    // Forwarding picks the youngest duplicate; address 0 never hits.
    step(1, 7, 32'hA, 1, 7, 32'hB, 0, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    chk("fwd_hit", {31'd0, fwd_hit1}, 32'd1);
    chk("fwd_young", fwd_data1, 32'hB);
    chk("fwd_zero_hit", {31'd0, fwd_hit2}, 32'd0);
    chk("fwd_zero_data", fwd_data2, 32'd0);
    idle(3);

    // Reset with three entries queued.
    step(1, 9, 32'h9, 1, 10, 32'hA0, 0, 0);
    step(1, 11, 32'hB0, 1, 12, 32'hC0, 0, 0);
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_count3", {29'd0, count}, 32'd3);
    do_reset();
    idle(3);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if (i == 200) do_reset();
    end
    idle(DEPTH + 3);
    chk("drained", exq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in0_valid  in  1  pipeline writeback request; no backpressure.
REQ-007 in0_addr/in0_data  in  ADDR_W/DATA_W  pipeline destination register and value.
REQ-008 in1_valid  in  1  multi-cycle unit (div/load) writeback request.
REQ-009 in1_addr/in1_data  in  ADDR_W/DATA_W  multi-cycle unit destination and value.
REQ-010 in1_ready  out  1  in1 accepted on cycles where in1_valid && in1_ready.
REQ-011 we/waddr/wdata  out  1/ADDR_W/DATA_W  register-file write port drive.
REQ-012 fwd_addr1/fwd_addr2  in  ADDR_W  decode-stage lookup addresses.
REQ-013 fwd_hit1/fwd_hit2  out  1  lookup matched a queued entry.
REQ-014 fwd_data1/fwd_data2  out  DATA_W  value of matching entry.
REQ-015 count  out  log2(DEPTH)+1  entries held; full/empty out 1: count==DEPTH / count==0.

Function
REQ-016 SHALL be a circular FIFO; head/tail pointers wrap modulo DEPTH.
REQ-017 SHALL drive we=!empty, waddr/wdata = head entry; all three 0 when empty (combinational).
REQ-018 SHALL pop head every cycle count>0; exactly one register write per cycle max.
REQ-019 SHALL enqueue in0 whenever in0_valid, unconditionally.
REQ-020 SHALL drive in1_ready = (count != DEPTH), from registered count only.
REQ-021 Same-cycle in0 and accepted in1: in0 SHALL occupy older slot, in1 next slot.
REQ-022 Next count = count + push0 + push1 - pop; SHALL never exceed DEPTH (guaranteed by REQ-020).
REQ-023 Requests with addr==0 SHALL be discarded (not enqueued); in1 handshake still completes.
REQ-024 Empty queue with new pushes: no write that cycle; first write next cycle (latency 1 cycle).
REQ-025 Simultaneous pop and push on full queue (in0 only) SHALL keep count==DEPTH.
REQ-026 fwd_hitN SHALL be 1 iff fwd_addrN!=0 and a valid stored entry (head included) has that addr.
REQ-027 Multiple matches: fwd_dataN SHALL be youngest matching entry; fwd_dataN=0 when no hit.
REQ-028 Lookup SHALL not see same-cycle incoming requests (stored entries only).
REQ-029 Multiple entries with same addr SHALL all be written in order; no coalescing.

Reset
REQ-030 rst low SHALL immediately clear head, tail, count; we=0, waddr=0, wdata=0, fwd_hit*=0, in1_ready=1, empty=1.
REQ-031 Reset mid-operation SHALL drop all queued entries; storage array need not be cleared.
REQ-032 First accepted push SHALL be the first rising edge with rst high.

Verification
REQ-033 Single: in0 {addr 3, 0xDEADBEEF} one cycle on empty -> next cycle we=1 waddr=3 wdata=DEADBEEF, following cycle we=0, count 1->0.
REQ-034 Dual: in0 {5,0x11} and in1 {6,0x22} same cycle -> writes reg5=0x11 then reg6=0x22 on consecutive cycles.
REQ-035 Fill: in0+in1 valid every cycle from empty (DEPTH=4) -> count 2,3,4; in1_ready=0 at count 4; in0 continues, count stays 4, writes 1/cycle, no entry lost.
REQ-036 Zero: in0 {0,0x55} and in1 {0,0x66} -> in1_ready handshake done, count stays 0, we never 1.
REQ-037 Forward: queue {7,0xA},{7,0xB}, fwd_addr1=7, fwd_addr2=0 -> fwd_hit1=1 fwd_data1=0xB, fwd_hit2=0 fwd_data2=0.
REQ-038 Reset: assert rst low with count=3 asynchronously -> we=0, count=0, in1_ready=1 before next edge; no stale write after release.
